// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown sequencer and its datapath.
package countdown_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/loadable_downcounter.sv
// Loadable down-counter that saturates at zero; load has priority over decrement.
module loadable_downcounter
    import countdown_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero_c
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign zero_c = (count_q == '0);
    assign count  = count_q;

    // Decrement is suppressed at zero so the counter can never wrap.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && !zero_c) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/countdown_sequencer.sv
// IDLE/LOAD/RUN/DONE countdown controller around a loadable down-counter.
// Optional periodic reload from DONE is enabled by COUNTDOWN_AUTO_RELOAD_EN.
module countdown_sequencer
    import countdown_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             pause,
    input  logic             abort,
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    input  logic             auto_reload,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;

    logic             cnt_load_c;
    logic [WIDTH-1:0] cnt_val_c;
    logic             cnt_dec_c;
    logic             cnt_zero_c;
    logic             auto_reload_c;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    assign auto_reload_c = auto_reload;
`else
    assign auto_reload_c = 1'b0;
`endif

    loadable_downcounter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load_c),
        .load_val (cnt_val_c),
        .dec      (cnt_dec_c),
        .count    (count),
        .zero_c   (cnt_zero_c)
    );

    // Abort clears the counter by loading zero, so no separate clear port is needed.
    always_comb begin
        state_d    = state_q;
        reload_d   = reload_q;
        cnt_load_c = 1'b0;
        cnt_val_c  = '0;
        cnt_dec_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (load_val != '0) begin
                        reload_d = load_val;
                        state_d  = LOAD;
                    end else begin
                        state_d  = DONE;
                    end
                end
            end
            LOAD: begin
                cnt_load_c = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    cnt_val_c = reload_q;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    cnt_load_c = 1'b1;
                    state_d    = IDLE;
                end else if (!pause) begin
                    if (cnt_zero_c) begin
                        state_d = DONE;
                    end else begin
                        cnt_dec_c = 1'b1;
                        if (count == WIDTH'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = auto_reload_c ? LOAD : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == LOAD) || (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            reload_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed plus randomized bench for countdown_sequencer against a schedule-queue model.
module tb_countdown_sequencer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] load_val;
    logic         pause;
    logic         abort;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic         auto_reload;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] count;

    always #5 clk = ~clk;

    countdown_sequencer #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .load_val    (load_val),
        .pause       (pause),
        .abort       (abort),
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        .auto_reload (auto_reload),
`endif
        .busy        (busy),
        .done        (done),
        .count       (count)
    );

    // One entry per observable cycle: expected outputs, and whether pause may stall it.
    typedef struct {
        int cnt;
        bit bsy;
        bit dn;
        bit stallable;
    } exp_t;

    exp_t cur;
    exp_t fut[$];
    int   reload_m;
    bit   auto_m;
    int   n_vec;
    int   n_err;

    function automatic exp_t mk(int c, bit b, bit d, bit s);
        exp_t e;
        e.cnt = c;
        e.bsy = b;
        e.dn  = d;
        e.stallable = s;
        return e;
    endfunction

    // Expected output trace of one countdown from reload_m: load cycle, V..1, then done.
    task automatic schedule();
        cur = mk(cur.cnt, 1'b1, 1'b0, 1'b0);
        fut.delete();
        if (reload_m == 0) fut.push_back(mk(0, 1'b1, 1'b0, 1'b1));
        for (int v = reload_m; v >= 1; v--) fut.push_back(mk(v, 1'b1, 1'b0, 1'b1));
        fut.push_back(mk(0, 1'b0, 1'b1, 1'b0));
    endtask

    task automatic model_reset();
        fut.delete();
        cur = mk(0, 1'b0, 1'b0, 1'b0);
        reload_m = 0;
    endtask

    task automatic model_edge();
        bit idle;
        idle = !cur.bsy && !cur.dn;
        if (abort && cur.bsy) begin
            fut.delete();
            cur = mk(0, 1'b0, 1'b0, 1'b0);
        end else if (cur.stallable && pause) begin
            cur = cur;
        end else if (idle && start) begin
            if (load_val == '0) begin
                cur = mk(0, 1'b0, 1'b1, 1'b0);
            end else begin
                reload_m = int'(load_val);
                schedule();
            end
        end else if (fut.size() > 0) begin
            cur = fut.pop_front();
        end else if (cur.dn && auto_m) begin
            schedule();
        end else begin
            cur = mk(0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic check(string tag);
        n_vec++;
        assert (count === W'(cur.cnt)) else begin
            n_err++;
            $error("FAIL %s count got %0d expected %0d", tag, count, cur.cnt);
        end
        n_vec++;
        assert (busy === cur.bsy) else begin
            n_err++;
            $error("FAIL %s busy got %b expected %b", tag, busy, cur.bsy);
        end
        n_vec++;
        assert (done === cur.dn) else begin
            n_err++;
            $error("FAIL %s done got %b expected %b", tag, done, cur.dn);
        end
    endtask

    task automatic step(bit s, int v, bit p, bit a, string tag);
        start    = s;
        load_val = W'(v);
        pause    = p;
        abort    = a;
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic mid_cycle_reset(string tag);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check(tag);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        auto_m   = 1'b0;
        reset    = 1'b0;
        start    = 1'b0;
        load_val = '0;
        pause    = 1'b0;
        abort    = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        auto_reload = 1'b0;
`endif
        model_reset();
        #12;
        check("reset");
        reset = 1'b1;
        step(1'b0, 0, 1'b0, 1'b0, "idle");

        // Plain countdown from 5.
        step(1'b1, 5, 1'b0, 1'b0, "s1_start");
        repeat (8) step(1'b0, 0, 1'b0, 1'b0, "s1_run");

        // Pause for three edges while count is 3.
        step(1'b1, 5, 1'b0, 1'b0, "s2_start");
        repeat (3) step(1'b0, 0, 1'b0, 1'b0, "s2_run");
        repeat (3) step(1'b0, 0, 1'b1, 1'b0, "s2_pause");
        repeat (6) step(1'b0, 0, 1'b0, 1'b0, "s2_tail");

        // Abort while count is 2.
        step(1'b1, 5, 1'b0, 1'b0, "s3_start");
        repeat (4) step(1'b0, 0, 1'b0, 1'b0, "s3_run");
        step(1'b0, 0, 1'b0, 1'b1, "s3_abort");
        repeat (2) step(1'b0, 0, 1'b0, 1'b0, "s3_after");

        // Zero load value goes straight to done; abort in done is ignored.
        step(1'b1, 0, 1'b0, 1'b0, "s4_zero");
        step(1'b0, 0, 1'b0, 1'b1, "s4_after");
        step(1'b0, 0, 1'b0, 0, "s4_idle");

        // Maximum load value, full range.
        step(1'b1, 15, 1'b0, 1'b0, "s6_max");
        repeat (18) step(1'b0, 0, 1'b0, 1'b0, "s6_run");

        // Start while busy is ignored, then async reset at count 7.
        step(1'b1, 9, 1'b0, 1'b0, "s5_start");
        step(1'b1, 3, 1'b0, 1'b0, "s5_ign");
        step(1'b1, 2, 1'b0, 1'b0, "s5_ign2");
        step(1'b0, 0, 1'b0, 1'b0, "s5_at7");
        mid_cycle_reset("s5_rst");
        repeat (2) step(1'b0, 0, 1'b0, 1'b0, "s5_after");

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // Periodic reload from 2, then abort ends the loop.
        auto_reload = 1'b1;
        auto_m = 1'b1;
        step(1'b1, 2, 1'b0, 1'b0, "ar_start");
        repeat (12) step(1'b0, 0, 1'b0, 1'b0, "ar_loop");
        for (int k = 0; k < 8 && !cur.stallable; k++) step(1'b0, 0, 1'b0, 1'b0, "ar_seek");
        step(1'b0, 0, 1'b0, 1'b1, "ar_abort");
        repeat (4) step(1'b0, 0, 1'b0, 1'b0, "ar_stopped");
        auto_reload = 1'b0;
        auto_m = 1'b0;
        repeat (2) step(1'b0, 0, 1'b0, 1'b0, "ar_off");
`endif

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 2) == 0, int'($urandom_range(0, 15)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0, "rand");
            if ($urandom_range(0, 79) == 0) mid_cycle_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
